// File: rtl/row_mem_read_sched_if.sv
// Read bus from the scheduler to the IA/weight row memories, plus the
// aligned strobes and back-pressure shared with the PE array.
interface row_mem_read_sched_if #(
  parameter int NUM_IA_ROW_MEM      = 96,
  parameter int NUM_WEIGHT_ROW_MEM  = 3,
  parameter int IA_ROW_MEM_ADDR     = 6,
  parameter int WEIGHT_ROW_MEM_ADDR = 7
);
  logic [NUM_IA_ROW_MEM-1:0]      ia_rd_en;
  logic [IA_ROW_MEM_ADDR-1:0]     ia_rd_addr;
  logic [NUM_WEIGHT_ROW_MEM-1:0]  w_rd_en;
  logic [WEIGHT_ROW_MEM_ADDR-1:0] w_rd_addr;
  logic                           pe_valid;
  logic                           pe_first;
  logic                           pe_last;
  logic [4:0]                     pe_oc;
  logic [4:0]                     pe_ow;
  logic                           pe_stall;

  modport master (
    output ia_rd_en, ia_rd_addr, w_rd_en, w_rd_addr,
    output pe_valid, pe_first, pe_last, pe_oc, pe_ow,
    input  pe_stall
  );

  modport slave (
    input  ia_rd_en, ia_rd_addr, w_rd_en, w_rd_addr,
    input  pe_valid, pe_first, pe_last, pe_oc, pe_ow,
    output pe_stall
  );
endinterface

// File: rtl/row_mem_read_sched.sv
// Walks the oc/ow/kw loop nest, issuing one row-memory read per cycle, and
// delivers PE strobes delayed one cycle so they line up with the read data.
module row_mem_read_sched #(
  parameter int NUM_ROWS            = 32,
  parameter int NUM_IA_ROW_MEM      = 96,
  parameter int NUM_WEIGHT_ROW_MEM  = 3,
  parameter int IA_ROW_MEM_ADDR     = 6,
  parameter int WEIGHT_ROW_MEM_ADDR = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [2:0]                 K,
  input  logic [5:0]                 IMG_H,
  input  logic [5:0]                 IMG_W,
  input  logic [7:0]                 OC,
  input  logic [2:0]                 STRIDE,
  row_mem_read_sched_if.master       rd,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err
);

  typedef enum logic [2:0] {IDLE, CHECK, RUN, DRAIN, DONE} state_t;

  state_t                          state;
  logic [2:0]                      k_r;
  logic [5:0]                      h_r;
  logic [5:0]                      w_r;
  logic [7:0]                      oc_r;
  logic [2:0]                      stride_r;
  logic [4:0]                      oc_cnt;
  logic [4:0]                      ow_cnt;
  logic [1:0]                      kw_cnt;
  logic [NUM_IA_ROW_MEM-1:0]       ia_mask;
  logic [NUM_WEIGHT_ROW_MEM-1:0]   w_mask;
  logic                            pe_valid_q;
  logic                            pe_first_q;
  logic                            pe_last_q;
  logic [4:0]                      pe_oc_q;
  logic [4:0]                      pe_ow_q;

  logic                            issue;
  logic                            in_run;
  logic                            kw_last;
  logic                            ow_last;
  logic                            oc_last;
  logic [8:0]                      row_len;
  logic                            cfg_ok;

  // Row r of kernel-row group kh is active when kh < K and r < IMG_H.
  function automatic logic [NUM_IA_ROW_MEM-1:0] ia_mask_of(input logic [2:0] k,
                                                           input logic [5:0] h);
    logic [NUM_IA_ROW_MEM-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_IA_ROW_MEM; i++)
      m[i] = ((i / NUM_ROWS) < int'(k)) && ((i % NUM_ROWS) < int'(h));
    return m;
  endfunction

  function automatic logic [NUM_WEIGHT_ROW_MEM-1:0] w_mask_of(input logic [2:0] k);
    logic [NUM_WEIGHT_ROW_MEM-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_WEIGHT_ROW_MEM; i++)
      m[i] = (i < int'(k));
    return m;
  endfunction

  assign in_run  = (state == RUN);
  assign issue   = in_run && !rd.pe_stall;
  assign kw_last = ({1'b0, kw_cnt} == (k_r - 3'd1));
  assign ow_last = ({1'b0, ow_cnt} == (w_r - 6'd1));
  assign oc_last = ({3'b0, oc_cnt} == (oc_r - 8'd1));

  // Input row length must fit the 64-entry IA row memory.
  assign row_len = (9'(w_r) - 9'd1) * 9'(stride_r) + 9'(k_r);
  assign cfg_ok  = (k_r >= 3'd1) && (k_r <= 3'd3) &&
                   (h_r >= 6'd1) && (h_r <= 6'(NUM_ROWS)) &&
                   (w_r >= 6'd1) && (w_r <= 6'd32) &&
                   (oc_r >= 8'd1) && (oc_r <= 8'd32) &&
                   (stride_r >= 3'd1) && (stride_r <= 3'd4) &&
                   (row_len <= 9'd64);

  assign rd.ia_rd_en   = issue ? ia_mask : '0;
  assign rd.w_rd_en    = issue ? w_mask : '0;
  assign rd.ia_rd_addr = in_run ?
      IA_ROW_MEM_ADDR'(9'(ow_cnt) * 9'(stride_r) + 9'(kw_cnt)) : '0;
  assign rd.w_rd_addr  = in_run ?
      WEIGHT_ROW_MEM_ADDR'(9'(oc_cnt) * 9'(k_r) + 9'(kw_cnt)) : '0;
  assign rd.pe_valid   = pe_valid_q;
  assign rd.pe_first   = pe_first_q;
  assign rd.pe_last    = pe_last_q;
  assign rd.pe_oc      = pe_oc_q;
  assign rd.pe_ow      = pe_ow_q;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      k_r        <= '0;
      h_r        <= '0;
      w_r        <= '0;
      oc_r       <= '0;
      stride_r   <= '0;
      oc_cnt     <= '0;
      ow_cnt     <= '0;
      kw_cnt     <= '0;
      ia_mask    <= '0;
      w_mask     <= '0;
      pe_valid_q <= 1'b0;
      pe_first_q <= 1'b0;
      pe_last_q  <= 1'b0;
      pe_oc_q    <= '0;
      pe_ow_q    <= '0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      done       <= 1'b0;
      pe_valid_q <= issue;
      pe_first_q <= issue && (kw_cnt == 2'd0);
      pe_last_q  <= issue && kw_last;
      if (issue) begin
        pe_oc_q <= oc_cnt;
        pe_ow_q <= ow_cnt;
      end
      case (state)
        IDLE: begin
          if (start) begin
            k_r      <= K;
            h_r      <= IMG_H;
            w_r      <= IMG_W;
            oc_r     <= OC;
            stride_r <= STRIDE;
            cfg_err  <= 1'b0;
            state    <= CHECK;
          end
        end
        CHECK: begin
          if (!cfg_ok) begin
            cfg_err <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            oc_cnt  <= '0;
            ow_cnt  <= '0;
            kw_cnt  <= '0;
            ia_mask <= ia_mask_of(k_r, h_r);
            w_mask  <= w_mask_of(k_r);
            state   <= RUN;
          end
        end
        RUN: begin
          // kw is innermost, then ow, then oc; the final wrap ends the walk.
          if (!rd.pe_stall) begin
            if (kw_last) begin
              kw_cnt <= '0;
              if (ow_last) begin
                ow_cnt <= '0;
                if (oc_last) state <= DRAIN;
                else         oc_cnt <= oc_cnt + 5'd1;
              end else begin
                ow_cnt <= ow_cnt + 5'd1;
              end
            end else begin
              kw_cnt <= kw_cnt + 2'd1;
            end
          end
        end
        DRAIN: begin
          done  <= 1'b1;
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_row_mem_read_sched.sv
// Randomized self-checking bench for row_mem_read_sched against a loop-nest
// reference model of the schedule and its cycle timing.
module tb_row_mem_read_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] k_in;
  logic [5:0] h_in;
  logic [5:0] w_in;
  logic [7:0] oc_in;
  logic [2:0] stride_in;
  logic       busy;
  logic       done;
  logic       cfg_err;

  int errors = 0;
  int checks = 0;
  bit prev_err = 1'b0;

  typedef struct {
    int ia;
    int w;
    int oc;
    int ow;
    int kw;
  } issue_t;

  row_mem_read_sched_if rd_if ();

  row_mem_read_sched dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .K      (k_in),
    .IMG_H  (h_in),
    .IMG_W  (w_in),
    .OC     (oc_in),
    .STRIDE (stride_in),
    .rd     (rd_if),
    .busy   (busy),
    .done   (done),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] got,
                             input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one schedule from the start cycle (cycle 0) and checks every cycle.
  // stall_mode: 0 none, 1 random, 2 stall on cycles 5..7.
  task automatic applyStimulus(input int k, input int h, input int w, input int oc,
                               input int s, input int stall_mode, input int reset_at,
                               input bit extra_start, output int done_obs);
    issue_t     q[$];
    issue_t     item;
    issue_t     prev;
    bit         legal;
    bit         stall;
    bit         exp_issue;
    bit         prev_issue;
    bit         ended;
    int         n;
    int         issued;
    int         exp_done;
    logic [95:0] ia_mask;
    logic [2:0]  w_mask;

    legal = (k >= 1 && k <= 3) && (h >= 1 && h <= 32) && (w >= 1 && w <= 32) &&
            (oc >= 1 && oc <= 32) && (s >= 1 && s <= 4) && ((w - 1) * s + k <= 64);
    n = legal ? oc * w * k : 0;
    if (legal)
      for (int o = 0; o < oc; o++)
        for (int x = 0; x < w; x++)
          for (int kw = 0; kw < k; kw++) begin
            item.ia = (x * s + kw) % 64;
            item.w  = (o * k + kw) % 128;
            item.oc = o;
            item.ow = x;
            item.kw = kw;
            q.push_back(item);
          end
    ia_mask = '0;
    for (int i = 0; i < 96; i++) ia_mask[i] = (i / 32 < k) && (i % 32 < h);
    w_mask = '0;
    for (int i = 0; i < 3; i++) w_mask[i] = (i < k);

    k_in = 3'(k); h_in = 6'(h); w_in = 6'(w); oc_in = 8'(oc); stride_in = 3'(s);
    exp_done   = legal ? -1 : 2;
    done_obs   = -1;
    issued     = 0;
    prev_issue = 1'b0;
    prev       = '{0, 0, 0, 0, 0};
    ended      = 1'b0;

    for (int c = 0; c < 20000; c++) begin
      if (reset_at >= 0 && c == reset_at + 1) begin
        reset = 1'b0; start = 1'b0; rd_if.pe_stall = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_cfg_err", cfg_err, 0);
        checkOutput("rst_pe_valid", rd_if.pe_valid, 0);
        checkOutput("rst_ia_rd_en", rd_if.ia_rd_en, 0);
        checkOutput("rst_w_rd_en", rd_if.w_rd_en, 0);
        checkOutput("rst_ia_rd_addr", rd_if.ia_rd_addr, 0);
        checkOutput("rst_pe_oc", rd_if.pe_oc, 0);
        @(posedge clk); #1;
        prev_err = 1'b0;
        ended = 1'b1;
        break;
      end
      case (stall_mode)
        1:       stall = ($urandom_range(0, 3) == 0);
        2:       stall = (c >= 5 && c <= 7);
        default: stall = 1'b0;
      endcase
      start = (c == 0) || (extra_start && c >= 1 && (exp_done < 0 || c <= exp_done) &&
                           $urandom_range(0, 5) == 0);
      reset = (c == reset_at);
      rd_if.pe_stall = stall;
      exp_issue = legal && c >= 2 && issued < n && !stall;

      @(negedge clk);
      checkOutput("ia_rd_en", rd_if.ia_rd_en, exp_issue ? ia_mask : 96'd0);
      checkOutput("w_rd_en", rd_if.w_rd_en, exp_issue ? w_mask : 3'd0);
      if (legal && c >= 2 && issued < n) begin
        checkOutput("ia_rd_addr", rd_if.ia_rd_addr, 128'(q[0].ia));
        checkOutput("w_rd_addr", rd_if.w_rd_addr, 128'(q[0].w));
      end
      checkOutput("pe_valid", rd_if.pe_valid, prev_issue);
      if (prev_issue) begin
        checkOutput("pe_first", rd_if.pe_first, prev.kw == 0);
        checkOutput("pe_last", rd_if.pe_last, prev.kw == k - 1);
        checkOutput("pe_oc", rd_if.pe_oc, 128'(prev.oc));
        checkOutput("pe_ow", rd_if.pe_ow, 128'(prev.ow));
      end
      checkOutput("done", done, c == exp_done);
      checkOutput("busy", busy, c >= 1 && (exp_done < 0 || c <= exp_done));
      checkOutput("cfg_err", cfg_err, (c == 0) ? prev_err : (!legal && c >= 2));
      if (done === 1'b1 && done_obs < 0) done_obs = c;

      if (exp_issue) begin
        prev = q.pop_front();
        issued++;
        if (issued == n) exp_done = c + 2;
      end
      prev_issue = exp_issue;

      @(posedge clk); #1;
      if (exp_done >= 0 && c == exp_done + 1) begin
        ended = 1'b1;
        break;
      end
    end
    checkOutput("run_ended", ended, 1);
    if (reset_at < 0) prev_err = !legal;
    start = 1'b0;
    reset = 1'b0;
    rd_if.pe_stall = 1'b0;
  endtask

  initial begin
    int dc;
    int k, h, w, oc, s;
    reset = 1'b1;
    start = 1'b0;
    rd_if.pe_stall = 1'b0;
    k_in = '0; h_in = '0; w_in = '0; oc_in = '0; stride_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_cfg_err", cfg_err, 0);
    checkOutput("reset_pe_valid", rd_if.pe_valid, 0);
    checkOutput("reset_ia_rd_en", rd_if.ia_rd_en, 0);
    checkOutput("reset_w_rd_addr", rd_if.w_rd_addr, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    applyStimulus(3, 32, 4, 2, 1, 0, -1, 1'b0, dc);
    checkOutput("t1_done_cycle", dc, 27);
    applyStimulus(1, 5, 32, 1, 1, 0, -1, 1'b0, dc);
    checkOutput("t2_done_cycle", dc, 35);
    applyStimulus(3, 32, 32, 1, 2, 1, -1, 1'b0, dc);
    checkOutput("t3_done_cycle", dc, 2);
    applyStimulus(3, 32, 4, 2, 1, 2, -1, 1'b0, dc);
    checkOutput("t4_done_cycle", dc, 30);
    applyStimulus(3, 32, 4, 2, 1, 0, 10, 1'b0, dc);
    applyStimulus(3, 32, 4, 2, 1, 0, -1, 1'b0, dc);
    checkOutput("t5_rerun_done_cycle", dc, 27);
    applyStimulus(3, 32, 4, 2, 1, 0, -1, 1'b1, dc);
    checkOutput("t6_done_cycle", dc, 27);

    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        k  = $urandom_range(0, 7);
        h  = $urandom_range(0, 63);
        w  = $urandom_range(0, 63);
        oc = $urandom_range(0, 40);
        s  = $urandom_range(0, 7);
      end else begin
        k  = $urandom_range(1, 3);
        s  = $urandom_range(1, 4);
        w  = $urandom_range(1, ((64 - k) / s + 1 > 32) ? 32 : (64 - k) / s + 1);
        oc = $urandom_range(1, 4);
        h  = $urandom_range(1, 32);
      end
      applyStimulus(k, h, w, oc, s, 1, -1, 1'b1, dc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
